// File: rtl/satsub8_serial.sv
// Bit-serial saturating subtractor: one full-adder slice computes a + ~b + 1
// LSB first over WIDTH cycles, then clamps the difference on a sign-rule overflow.
module satsub8_serial #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] S_MAX    = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] S_MIN    = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] raw_q, raw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             ovf_q, ovf_d;

  // Single full-adder slice on the current LSBs, subtrahend inverted.
  logic             b_inv_c;
  logic             sum_bit_c;
  logic             carry_nxt_c;
  logic [WIDTH-1:0] raw_shift_c;
  logic             ovf_c;

  always_comb begin
    b_inv_c     = ~b_q[0];
    sum_bit_c   = a_q[0] ^ b_inv_c ^ carry_q;
    carry_nxt_c = (a_q[0] & b_inv_c) | (a_q[0] & carry_q) | (b_inv_c & carry_q);
    raw_shift_c = {sum_bit_c, (WIDTH-1)'(raw_q >> 1)};
    // Operand signs are held separately since A/B are shifted away during RUN.
    ovf_c       = (sign_a_q != sign_b_q) && (raw_shift_c[WIDTH-1] != sign_a_q);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    raw_d    = raw_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    s_d      = s_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = RUN;
          a_d      = a;
          b_d      = b;
          sign_a_d = a[WIDTH-1];
          sign_b_d = b[WIDTH-1];
          carry_d  = 1'b1;
          cnt_d    = '0;
          raw_d    = '0;
          busy_d   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = carry_nxt_c;
        raw_d   = raw_shift_c;
        cnt_d   = cnt_q + CNT_W'(1);
        busy_d  = 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          ovf_d   = ovf_c;
          s_d     = ovf_c ? (sign_a_q ? S_MIN : S_MAX) : raw_shift_c;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      raw_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      s_q      <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      raw_q    <= raw_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      s_q      <= s_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_satsub8_serial.sv
// Bench for satsub8_serial: vector table, protocol corner sequences and a
// random sweep, checked through a protocol model plus result scoreboard.
module tb_satsub8_serial;

  typedef struct packed {
    logic [7:0] s;
    logic       ovf;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    exp_t       e;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] s;
  logic       ovf;

  int   n_chk  = 0;
  int   n_fail = 0;
  bit   chk_en = 0;

  exp_t drv_exp;
  exp_t exp_q[$];

  // Protocol model: 0 idle, 1 run, 2 done.
  int   m_state = 0;
  int   m_cnt   = 0;
  bit   m_rst   = 0;
  exp_t last_e  = '0;

  satsub8_serial #(.WIDTH(8), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t ref_sub(input logic [7:0] x, input logic [7:0] y);
    int   d;
    exp_t r;
    d = int'($signed(x)) - int'($signed(y));
    if (d > 127)       r = '{s: 8'h7F, ovf: 1'b1};
    else if (d < -128) r = '{s: 8'h80, ovf: 1'b1};
    else               r = '{s: 8'(d), ovf: 1'b0};
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_state <= 0;
      m_cnt   <= 0;
      m_rst   <= 1'b1;
      exp_q.delete();
    end else begin
      m_rst <= 1'b0;
      case (m_state)
        1: begin
          if (m_cnt == 7) m_state <= 2;
          else            m_cnt   <= m_cnt + 1;
        end
        default: begin
          if (start) begin
            m_state <= 1;
            m_cnt   <= 0;
            exp_q.push_back(drv_exp);
          end else begin
            m_state <= 0;
          end
        end
      endcase
    end
  end

  // Output checker, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e;
      if (m_rst) last_e = '0;
      chk("busy", int'(busy), int'(m_state == 1));
      chk("done", int'(done), int'(m_state == 2));
      if (m_state == 2) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard: got done with no expected result at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("s", int'(s), int'(e.s));
          chk("ovf", int'(ovf), int'(e.ovf));
          last_e = e;
        end
      end else begin
        chk("s_hold", int'(s), int'(last_e.s));
        chk("ovf_hold", int'(ovf), int'(last_e.ovf));
      end
    end
  end

  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input exp_t e);
    bit got;
    @(negedge clk);
    a = ia; b = ib; drv_exp = e; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'($urandom); b = 8'($urandom);
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      if (done) got = 1'b1;
      else @(negedge clk);
    end
    chk("done_timeout", int'(got), 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[14];
    logic [7:0] corner[8];
    int         dcyc[$];
    logic [7:0] ra, rb;

    tbl[0]  = '{8'h05, 8'h03, '{8'h02, 1'b0}};
    tbl[1]  = '{8'h64, 8'h9C, '{8'h7F, 1'b1}};
    tbl[2]  = '{8'h9C, 8'h64, '{8'h80, 1'b1}};
    tbl[3]  = '{8'h80, 8'h01, '{8'h80, 1'b1}};
    tbl[4]  = '{8'h00, 8'h80, '{8'h7F, 1'b1}};
    tbl[5]  = '{8'hFF, 8'h80, '{8'h7F, 1'b0}};
    tbl[6]  = '{8'h7F, 8'hFF, '{8'h7F, 1'b1}};
    tbl[7]  = '{8'h80, 8'h80, '{8'h00, 1'b0}};
    tbl[8]  = '{8'h7F, 8'h80, '{8'h7F, 1'b1}};
    tbl[9]  = '{8'h80, 8'h7F, '{8'h80, 1'b1}};
    tbl[10] = '{8'h00, 8'h01, '{8'hFF, 1'b0}};
    tbl[11] = '{8'h01, 8'h7F, '{8'h82, 1'b0}};
    tbl[12] = '{8'hFE, 8'h7F, '{8'h80, 1'b1}};
    tbl[13] = '{8'h7E, 8'hFF, '{8'h7F, 1'b0}};
    corner  = '{8'h00, 8'h01, 8'h7E, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF};

    reset = 1'b1; start = 1'b0; a = '0; b = '0; drv_exp = '0;
    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) run_op(tbl[i].a, tbl[i].b, tbl[i].e);

    // start held high: back-to-back operations every 9 cycles.
    @(negedge clk);
    a = 8'h07; b = 8'h02; drv_exp = '{8'h05, 1'b0}; start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 19) start = 1'b0;
      if (done) dcyc.push_back(i);
    end
    chk("b2b_count", dcyc.size(), 3);
    for (int i = 1; i < dcyc.size(); i++) chk("b2b_gap", dcyc[i] - dcyc[i-1], 9);

    // start during busy must be ignored.
    @(negedge clk);
    a = 8'h10; b = 8'h20; drv_exp = '{8'hF0, 1'b0}; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    a = 8'h55; b = 8'h11; drv_exp = '{8'h44, 1'b0}; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);

    // Reset in the fourth RUN cycle: operation dropped, no done.
    @(negedge clk);
    a = 8'h30; b = 8'h10; drv_exp = '{8'h20, 1'b0}; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);

    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        run_op(corner[i], corner[j], ref_sub(corner[i], corner[j]));

    for (int k = 0; k < 3000; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_op(ra, rb, ref_sub(ra, rb));
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
